// File: rtl/mem_bus_interface_pkg.sv
// Shared types and sizes for the LC-3 memory bus interface.
// Imported by the bus interface, the MAR register and the top.
package lc3_mem_pkg;

    localparam int WORD_W   = 16;
    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_bus_interface_if.sv
// Datapath-side bundle: bus value, load strobes, request handshake
// and the MAR/MDR views returned to the datapath.
interface mem_bus_if;
    import lc3_mem_pkg::*;

    logic [WORD_W-1:0] Data_Bus;
    logic              LD_MAR;
    logic              LD_MDR;
    logic              Mem_Req;
    logic              Mem_WE;
    logic              Mem_Ready;
    logic              Mem_Done;
    logic [WORD_W-1:0] MAR_Out;
    logic [WORD_W-1:0] MDR_Out;

    modport master (
        output Data_Bus,
        output LD_MAR,
        output LD_MDR,
        output Mem_Req,
        output Mem_WE,
        input  Mem_Ready,
        input  Mem_Done,
        input  MAR_Out,
        input  MDR_Out
    );

    modport slave (
        input  Data_Bus,
        input  LD_MAR,
        input  LD_MDR,
        input  Mem_Req,
        input  Mem_WE,
        output Mem_Ready,
        output Mem_Done,
        output MAR_Out,
        output MDR_Out
    );

endinterface

// File: rtl/mem_bus_interface_load_reg16.sv
// 16-bit register with synchronous active-low reset and load enable.
// Holds the memory address register.
module load_reg16
    import lc3_mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_i,
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] q_o
);

    logic [WORD_W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (ld_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_bus_interface.sv
// MAR/MDR capture from the datapath bus and a wait-stated,
// handshaked SRAM read/write cycle (IDLE/SETUP/ACCESS/DONE).
module mem_bus_interface
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic              Clk,
    input  logic              Reset,
    mem_bus_if.slave          bus,
    input  logic [WORD_W-1:0] MEM_DIN,
    output logic [WORD_W-1:0] MEM_ADDR,
    output logic [WORD_W-1:0] MEM_DOUT,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] mdr_q, mdr_d;
    logic [WORD_W-1:0] mar_q;
    logic              mar_ld;

    load_reg16 u_mar (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .ld_i   (mar_ld),
        .d_i    (bus.Data_Bus),
        .q_o    (mar_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mdr_d   = mdr_q;
        mar_ld  = 1'b0;
        unique case (state_q)
            IDLE: begin
                mar_ld = bus.LD_MAR;
                if (bus.LD_MDR) begin
                    mdr_d = bus.Data_Bus;
                end
                if (bus.Mem_Req) begin
                    we_d    = bus.Mem_WE;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        mdr_d = MEM_DIN;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mdr_q   <= mdr_d;
        end
    end

    // Strobes decode only from registered state, never from inputs.
    assign CE_N = !((state_q == SETUP) || (state_q == ACCESS));
    assign OE_N = !((state_q == ACCESS) && !we_q);
    assign WE_N = !((state_q == ACCESS) && we_q);

    assign bus.Mem_Ready = (state_q == IDLE);
    assign bus.Mem_Done  = (state_q == DONE);
    assign bus.MAR_Out   = mar_q;
    assign bus.MDR_Out   = mdr_q;

    assign MEM_ADDR = mar_q;
    assign MEM_DOUT = mdr_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Scoreboard bench for mem_bus_interface at WAIT_CYCLES 2, 1 and 15.
// Expected transactions are queued at request time, popped on Mem_Done.
module tb_mem_bus_interface;
    import lc3_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] data_bus, mem_din;
    logic        ld_mar, ld_mdr, mem_we;
    logic        req2, req1, req15;

    mem_bus_if b2 ();
    mem_bus_if b1 ();
    mem_bus_if b15 ();

    assign b2.Data_Bus  = data_bus;
    assign b2.LD_MAR    = ld_mar;
    assign b2.LD_MDR    = ld_mdr;
    assign b2.Mem_Req   = req2;
    assign b2.Mem_WE    = mem_we;
    assign b1.Data_Bus  = data_bus;
    assign b1.LD_MAR    = ld_mar;
    assign b1.LD_MDR    = ld_mdr;
    assign b1.Mem_Req   = req1;
    assign b1.Mem_WE    = mem_we;
    assign b15.Data_Bus = data_bus;
    assign b15.LD_MAR   = ld_mar;
    assign b15.LD_MDR   = ld_mdr;
    assign b15.Mem_Req  = req15;
    assign b15.Mem_WE   = mem_we;

    logic [15:0] addr2, dout2, addr1, dout1, addr15, dout15;
    logic        ce2, oe2, we2, ce1, oe1, we1, ce15, oe15, we15;

    mem_bus_interface #(.WAIT_CYCLES(2)) u2 (
        .Clk(clk), .Reset(rst_n), .bus(b2), .MEM_DIN(mem_din),
        .MEM_ADDR(addr2), .MEM_DOUT(dout2),
        .CE_N(ce2), .OE_N(oe2), .WE_N(we2)
    );
    mem_bus_interface #(.WAIT_CYCLES(1)) u1 (
        .Clk(clk), .Reset(rst_n), .bus(b1), .MEM_DIN(mem_din),
        .MEM_ADDR(addr1), .MEM_DOUT(dout1),
        .CE_N(ce1), .OE_N(oe1), .WE_N(we1)
    );
    mem_bus_interface #(.WAIT_CYCLES(15)) u15 (
        .Clk(clk), .Reset(rst_n), .bus(b15), .MEM_DIN(mem_din),
        .MEM_ADDR(addr15), .MEM_DOUT(dout15),
        .CE_N(ce15), .OE_N(oe15), .WE_N(we15)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        int          t0;
    } txn_t;

    txn_t sb[$];
    int   done2 = 0, we_run = 0, oe_run = 0, we_len = 0, oe_len = 0;
    int   we_low_total = 0;
    int   oe1_run = 0, oe1_len = 0, oe15_run = 0, oe15_len = 0;
    int   d1_t[$];
    int   d15_t[$];

    // Main instance: strobe rules, address/data hold, scoreboard pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            we_run = 0;
            oe_run = 0;
        end else begin
            chk("strobe_excl", {31'b0, oe2 | we2}, 1);
            if (!oe2 || !we2) chk("strobe_ce", {31'b0, ce2}, 0);
            if (!we2) begin
                we_run++;
                we_low_total++;
            end else if (we_run != 0) begin
                we_len = we_run;
                we_run = 0;
            end
            if (!oe2) oe_run++;
            else if (oe_run != 0) begin
                oe_len = oe_run;
                oe_run = 0;
            end
            if (!ce2 && sb.size() > 0) begin
                chk("addr_hold", {16'b0, addr2}, {16'b0, sb[0].addr});
                if (sb[0].we)
                    chk("dout_hold", {16'b0, dout2}, {16'b0, sb[0].data});
            end
            if (b2.Mem_Done) begin
                done2++;
                chk("done_has_txn", {31'b0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    txn_t t;
                    t = sb.pop_front();
                    chk("latency", cyc - t.t0, 4);
                    chk("done_addr", {16'b0, addr2}, {16'b0, t.addr});
                    chk("done_mdr", {16'b0, b2.MDR_Out}, {16'b0, t.data});
                    chk("done_strobes", {29'b0, ce2, oe2, we2}, 3'b111);
                    chk("done_ready", {31'b0, b2.Mem_Ready}, 0);
                end
            end
        end
    end

    // Sweep instances: strobe length and Mem_Done timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            oe1_run = 0;
            oe15_run = 0;
        end else begin
            if (!oe1) oe1_run++;
            else if (oe1_run != 0) begin
                oe1_len = oe1_run;
                oe1_run = 0;
            end
            if (!oe15) oe15_run++;
            else if (oe15_run != 0) begin
                oe15_len = oe15_run;
                oe15_run = 0;
            end
            if (b1.Mem_Done) begin
                d1_t.push_back(cyc);
                chk("u1_mdr", {16'b0, b1.MDR_Out}, {16'b0, mem_din});
            end
            if (b15.Mem_Done) begin
                d15_t.push_back(cyc);
                chk("u15_mdr", {16'b0, b15.MDR_Out}, {16'b0, mem_din});
            end
        end
    end

    task automatic load_mar(input logic [15:0] a);
        @(negedge clk);
        data_bus = a;
        ld_mar = 1'b1;
        @(posedge clk);
        #1 ld_mar = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] d);
        @(negedge clk);
        data_bus = d;
        ld_mdr = 1'b1;
        @(posedge clk);
        #1 ld_mdr = 1'b0;
    endtask

    task automatic start(input logic we, input logic [15:0] ea,
                         input logic [15:0] ed, input logic lm,
                         input logic [15:0] bv);
        @(negedge clk);
        chk("ready_at_req", {31'b0, b2.Mem_Ready}, 1);
        if (lm) begin
            data_bus = bv;
            ld_mar = 1'b1;
        end
        req2 = 1'b1;
        mem_we = we;
        sb.push_back('{we, ea, ed, cyc});
        @(posedge clk);
        #1;
        req2 = 1'b0;
        ld_mar = 1'b0;
    endtask

    task automatic wait_done2();
        int n;
        int k;
        n = done2;
        k = 0;
        while (done2 == n && k < 40) begin
            @(posedge clk);
            k++;
        end
        chk("done_timeout", {31'b0, done2 != n}, 1);
    endtask

    initial begin
        int d, wl, t0, k;
        rst_n = 1'b0;
        data_bus = '0;
        mem_din = '0;
        ld_mar = 1'b0;
        ld_mdr = 1'b0;
        mem_we = 1'b0;
        req2 = 1'b0;
        req1 = 1'b0;
        req15 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, b2.Mem_Ready}, 1);
        chk("rst_done", {31'b0, b2.Mem_Done}, 0);
        chk("rst_strobes", {29'b0, ce2, oe2, we2}, 3'b111);
        chk("rst_mar", {16'b0, b2.MAR_Out}, 0);
        chk("rst_mdr", {16'b0, b2.MDR_Out}, 0);

        // Reset in the middle of a write.
        load_mar(16'h1111);
        load_mdr(16'h2222);
        start(1'b1, 16'h1111, 16'h2222, 1'b0, 16'h0);
        @(posedge clk);
        #1 chk("we_low_access", {31'b0, we2}, 0);
        @(negedge clk);
        sb.delete();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_we", {31'b0, we2}, 1);
        chk("midrst_ce", {31'b0, ce2}, 1);
        chk("midrst_mar", {16'b0, b2.MAR_Out}, 0);
        chk("midrst_mdr", {16'b0, b2.MDR_Out}, 0);
        chk("midrst_ready", {31'b0, b2.Mem_Ready}, 1);
        chk("midrst_done", {31'b0, b2.Mem_Done}, 0);
        @(negedge clk) rst_n = 1'b1;
        d = done2;
        repeat (6) @(posedge clk);
        chk("midrst_no_done", done2, d);

        // Write x3000 <- xBEEF.
        load_mar(16'h3000);
        load_mdr(16'hBEEF);
        start(1'b1, 16'h3000, 16'hBEEF, 1'b0, 16'h0);
        wait_done2();
        chk("we_len", we_len, 2);
        chk("wr_mdr_kept", {16'b0, b2.MDR_Out}, 16'hBEEF);

        // Read x0040 -> x1234, no write strobe.
        mem_din = 16'h1234;
        load_mar(16'h0040);
        wl = we_low_total;
        start(1'b0, 16'h0040, 16'h1234, 1'b0, 16'h0);
        wait_done2();
        chk("oe_len", oe_len, 2);
        chk("rd_no_we", we_low_total, wl);

        // Same-cycle MAR load and read request.
        mem_din = 16'hA5C3;
        start(1'b0, 16'h00FF, 16'hA5C3, 1'b1, 16'h00FF);
        wait_done2();
        chk("same_cyc_mar", {16'b0, b2.MAR_Out}, 16'h00FF);

        // Loads and a second request during ACCESS are ignored.
        load_mdr(16'hBEEF);
        start(1'b1, 16'h00FF, 16'hBEEF, 1'b0, 16'h0);
        @(posedge clk);
        @(negedge clk);
        data_bus = 16'h5555;
        ld_mdr = 1'b1;
        ld_mar = 1'b1;
        req2 = 1'b1;
        mem_we = 1'b0;
        @(posedge clk);
        #1;
        ld_mdr = 1'b0;
        ld_mar = 1'b0;
        req2 = 1'b0;
        d = done2;
        wait_done2();
        repeat (8) @(posedge clk);
        chk("single_done", done2, d + 1);
        chk("access_mdr_frozen", {16'b0, b2.MDR_Out}, 16'hBEEF);
        chk("access_mar_frozen", {16'b0, b2.MAR_Out}, 16'h00FF);

        // Back-to-back reads with Mem_Req held, WAIT_CYCLES=1.
        mem_din = 16'h0F0F;
        mem_we = 1'b0;
        @(negedge clk);
        t0 = cyc;
        req1 = 1'b1;
        k = 0;
        while (d1_t.size() < 3 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1 req1 = 1'b0;
        chk("u1_three_done", {31'b0, d1_t.size() >= 3}, 1);
        if (d1_t.size() >= 3) begin
            chk("u1_first_lat", d1_t[0] - t0, 3);
            chk("u1_period_a", d1_t[1] - d1_t[0], 4);
            chk("u1_period_b", d1_t[2] - d1_t[1], 4);
        end
        chk("u1_oe_len", oe1_len, 1);
        repeat (8) @(posedge clk);

        // Single read at WAIT_CYCLES=15.
        @(negedge clk);
        t0 = cyc;
        req15 = 1'b1;
        @(posedge clk);
        #1 req15 = 1'b0;
        k = 0;
        while (d15_t.size() == 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        chk("u15_done", {31'b0, d15_t.size() != 0}, 1);
        if (d15_t.size() != 0) chk("u15_lat", d15_t[0] - t0, 17);
        chk("u15_oe_len", oe15_len, 15);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_interface.md
Name: mem_bus_interface

Overview:
Receiving end of the shared 16-bit datapath bus. It captures bus values into MAR and MDR under load strobes, then runs a handshaked, wait-stated read or write cycle to the external SRAM. MAR_Out drives the memory address. MDR_Out returns to the bus gating mux as the GateMDR source. It sits between the datapath bus, the ISDU control FSM and the SRAM pins.

Parameters:
WAIT_CYCLES, 2, number of cycles the strobe phase (OE_N or WE_N low) lasts; legal range 1..15.

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-low reset
Data_Bus  input  16  shared datapath bus; may be X when no gate is driving it
LD_MAR  input  1  load MAR from Data_Bus
LD_MDR  input  1  load MDR from Data_Bus
Mem_Req  input  1  request a memory cycle
Mem_WE  input  1  cycle type, sampled with Mem_Req: 1 = write MDR to mem[MAR], 0 = read mem[MAR] into MDR
Mem_Ready  output  1  high only in IDLE; a request is accepted only while this is high
Mem_Done  output  1  one-cycle pulse marking completion of a memory cycle
MAR_Out  output  16  current MAR contents
MDR_Out  output  16  current MDR contents, fed to the bus gate mux
MEM_ADDR  output  16  equals MAR_Out at all times
MEM_DOUT  output  16  equals MDR_Out at all times
MEM_DIN  input  16  SRAM read data
CE_N  output  1  SRAM chip enable, active-low
OE_N  output  1  SRAM output enable, active-low
WE_N  output  1  SRAM write enable, active-low

Behaviour:
- Reset (Reset=0 at an edge), also mid-cycle:
  - state returns to IDLE; MAR and MDR clear to 0; wait counter clears to 0; latched cycle type clears.
  - After that edge: Mem_Ready=1, Mem_Done=0, CE_N=OE_N=WE_N=1.
  - No partial write completes; WE_N is high from the reset edge onward.
- Registers:
  - In IDLE: LD_MAR=1 -> MAR <= Data_Bus. LD_MDR=1 -> MDR <= Data_Bus.
  - In SETUP, ACCESS and DONE, LD_MAR and LD_MDR are ignored. MAR and MDR stay frozen except for the read-data capture below.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: if Mem_Req=1, latch Mem_WE, go to SETUP.
  - SETUP: 1 cycle, CE_N=0, address and data stable. Wait counter loads WAIT_CYCLES-1. Go to ACCESS.
  - ACCESS: CE_N=0, plus OE_N=0 for a read or WE_N=0 for a write. Counter decrements each cycle. When counter=0: on a read, MDR <= MEM_DIN at that edge; then go to DONE.
  - DONE: 1 cycle, Mem_Done=1, all strobes high. Go to IDLE.
- Latency: request accepted at edge E -> Mem_Done high in cycle E+WAIT_CYCLES+2. Read data is visible on MDR_Out in that same DONE cycle.
- Simultaneous events:
  - LD_MAR and Mem_Req in the same IDLE cycle: the access uses the newly loaded MAR.
  - LD_MDR and a write request in the same IDLE cycle: the access writes the newly loaded MDR.
- Mem_Req while not in IDLE is ignored; requests are not queued. Mem_Req held high through DONE starts the next cycle from IDLE one cycle later. Back-to-back period is WAIT_CYCLES+3.
- Strobe rules:
  - WE_N and OE_N are never low in the same cycle.
  - Neither strobe is low outside ACCESS.
  - CE_N is low only in SETUP and ACCESS.
  - All SRAM control outputs are registered or decoded from state only; no combinational path from inputs.
- Widths: counter width = $clog2(WAIT_CYCLES+1); decrement never wraps below 0.
- Data_Bus=X while a load strobe is high is a controller error; this block does not check for it.

Decomposition:
- Package lc3_mem_pkg holds:
  - typedef enum logic[1:0] mem_state_t {IDLE, SETUP, ACCESS, DONE}
  - WORD_W=16
  - MAX_WAIT=15
- One natural sub-module, load_reg16: 16-bit register with synchronous active-low reset and a load enable, instantiated for MAR.
- MDR stays inline because it has two sources (Data_Bus and MEM_DIN).

Test Plan:
1. Reset mid-write: reset after 1 ACCESS cycle -> WE_N=1 from the reset edge; MAR=MDR=0, Mem_Ready=1, no Mem_Done pulse.
2. Load MAR=x3000 and MDR=xBEEF, then write request (WAIT_CYCLES=2) -> WE_N low exactly 2 cycles with MEM_ADDR=x3000 and MEM_DOUT=xBEEF; Mem_Done pulses 4 cycles after acceptance.
3. Read with MEM_DIN=x1234 at MAR=x0040 -> OE_N low 2 cycles; MDR_Out=x1234 in the DONE cycle; WE_N never low.
4. Same-cycle LD_MAR(Data_Bus=x00FF) and read request -> MEM_ADDR=x00FF throughout SETUP and ACCESS.
5. LD_MDR with Data_Bus=x5555 pulsed during ACCESS -> MDR unchanged; second Mem_Req during ACCESS ignored (single Mem_Done).
6. Mem_Req held high for 3 reads at WAIT_CYCLES=1 -> Mem_Done pulses every 4 cycles; sweep WAIT_CYCLES=1 and 15 to check strobe length.
